// File: rtl/alu_muldiv_controller.sv
// R-type ALU decode plus an iterative shift-add / restoring-divide engine for the M extension.
// Optional build macro ALU_MULDIV_EARLY_OUT_EN: special divides and short multiplies finish early.
module alu_muldiv_controller #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            is_op_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [3:0]      alu_op_o,
    output logic            illegal_o,
    output logic            ready_o,
    output logic            stall_o,
    output logic [XLEN-1:0] result_o,
    output logic            result_valid_o
);
    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [2:0]        op_q;
    logic              neg_q, neg_rem_q, divz_q, ovf_q, result_valid_q;
    logic [XLEN-1:0]   rs1_q, mplier_q, mplier_d, result_q;
    logic [2*XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d;

    logic              m_op, accept, sgn1, sgn2, neg1, neg2, divz, ovf, mul_last;
    logic [XLEN-1:0]   mag1, mag2, quot, rem, fin, rem_sub;
    logic [XLEN:0]     rem_ext;
    logic [2*XLEN-1:0] prod;

    // Div-by-zero and signed-overflow results; op[1] separates REM* from DIV*.
    function automatic logic [XLEN-1:0] special_res(input logic [2:0] op, input logic dz,
                                                    input logic [XLEN-1:0] a);
        if (op[1]) return dz ? a : '0;
        return dz ? '1 : a;
    endfunction

    always_comb begin
        alu_op_o  = 4'd0;
        illegal_o = 1'b0;
        if (is_op_i) begin
            case (funct7_i)
                7'h00: begin
                    case (funct3_i)
                        3'd0:    alu_op_o = 4'd0;
                        3'd1:    alu_op_o = 4'd2;
                        3'd2:    alu_op_o = 4'd3;
                        3'd3:    alu_op_o = 4'd4;
                        3'd4:    alu_op_o = 4'd5;
                        3'd5:    alu_op_o = 4'd6;
                        3'd6:    alu_op_o = 4'd8;
                        default: alu_op_o = 4'd9;
                    endcase
                end
                7'h20: begin
                    if (funct3_i == 3'd0)      alu_op_o = 4'd1;
                    else if (funct3_i == 3'd5) alu_op_o = 4'd7;
                    else                       illegal_o = 1'b1;
                end
                7'h01:   illegal_o = 1'b0;
                default: illegal_o = 1'b1;
            endcase
        end
    end

    always_comb begin
        m_op   = is_op_i && (funct7_i == 7'h01);
        accept = valid_i && m_op && (state_q == StIdle);
        sgn1   = (funct3_i == 3'd1) || (funct3_i == 3'd2) || (funct3_i == 3'd4) ||
                 (funct3_i == 3'd6);
        sgn2   = (funct3_i == 3'd1) || (funct3_i == 3'd4) || (funct3_i == 3'd6);
        neg1   = sgn1 && rs1_i[XLEN-1];
        neg2   = sgn2 && rs2_i[XLEN-1];
        mag1   = neg1 ? '0 - rs1_i : rs1_i;
        mag2   = neg2 ? '0 - rs2_i : rs2_i;
        divz   = funct3_i[2] && (rs2_i == '0);
        ovf    = ((funct3_i == 3'd4) || (funct3_i == 3'd6)) &&
                 (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
    end

    // One iteration per cycle: acc holds the product (MUL) or {remainder, quotient} (DIV).
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_ext  = '0;
        rem_sub  = '0;
        if (state_q == StMul) begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end else if (state_q == StDiv) begin
            rem_ext = acc_q[2*XLEN-1:XLEN-1];
            rem_sub = XLEN'(rem_ext - {1'b0, mplier_q});
            if (rem_ext >= {1'b0, mplier_q}) acc_d = {rem_sub, acc_q[XLEN-2:0], 1'b1};
            else                             acc_d = {acc_q[2*XLEN-2:0], 1'b0};
        end
    end

    always_comb begin
        prod = neg_q ? '0 - acc_d : acc_d;
        quot = neg_q ? '0 - acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
        rem  = neg_rem_q ? '0 - acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
        if (!op_q[2])              fin = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else if (divz_q || ovf_q)  fin = special_res(op_q, divz_q, rs1_q);
        else                       fin = op_q[1] ? rem : quot;
    end

`ifdef ALU_MULDIV_EARLY_OUT_EN
    assign mul_last = (cnt_q == CntLast) || (mplier_d == '0);
`else
    assign mul_last = (cnt_q == CntLast);
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            op_q           <= '0;
            neg_q          <= 1'b0;
            neg_rem_q      <= 1'b0;
            divz_q         <= 1'b0;
            ovf_q          <= 1'b0;
            rs1_q          <= '0;
            acc_q          <= '0;
            mcand_q        <= '0;
            mplier_q       <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            acc_q          <= acc_d;
            mcand_q        <= mcand_d;
            mplier_q       <= mplier_d;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q      <= funct3_i;
                        neg_q     <= neg1 ^ neg2;
                        neg_rem_q <= neg1;
                        divz_q    <= divz;
                        ovf_q     <= ovf;
                        rs1_q     <= rs1_i;
                        cnt_q     <= '0;
                        mplier_q  <= mag2;
                        mcand_q   <= {{XLEN{1'b0}}, mag1};
                        acc_q     <= funct3_i[2] ? {{XLEN{1'b0}}, mag1} : '0;
                        state_q   <= funct3_i[2] ? StDiv : StMul;
`ifdef ALU_MULDIV_EARLY_OUT_EN
                        if (divz || ovf) begin
                            state_q        <= StDone;
                            result_q       <= special_res(funct3_i, divz, rs1_i);
                            result_valid_q <= 1'b1;
                        end
`endif
                    end
                end
                StMul, StDiv: begin
                    cnt_q <= cnt_q + 1'b1;
                    if ((state_q == StMul) ? mul_last : (cnt_q == CntLast)) begin
                        state_q        <= StDone;
                        result_q       <= fin;
                        result_valid_q <= 1'b1;
                    end
                end
                StDone: state_q <= StIdle;
            endcase
        end
    end

    assign ready_o        = (state_q == StIdle);
    assign stall_o        = ((state_q == StIdle) && valid_i && m_op) ||
                            (state_q == StMul) || (state_q == StDiv);
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;

endmodule

// File: tb/tb_alu_muldiv_controller.sv
// Scoreboard bench for alu_muldiv_controller: random M ops against a plain-arithmetic model.
module tb_alu_muldiv_controller;
    localparam int unsigned XLEN = 32;
    localparam logic [31:0] MinInt = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n, is_op, valid;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1, rs2;
    logic [3:0]  alu_op;
    logic        illegal, ready, stall, res_valid;
    logic [31:0] result;

    alu_muldiv_controller #(.XLEN(XLEN)) dut (
        .clk_i(clk), .rst_ni(rst_n), .is_op_i(is_op), .funct3_i(f3), .funct7_i(f7),
        .valid_i(valid), .rs1_i(rs1), .rs2_i(rs2), .alu_op_o(alu_op), .illegal_o(illegal),
        .ready_o(ready), .stall_o(stall), .result_o(result), .result_valid_o(res_valid)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    int unsigned lat_q[$];
    int unsigned t0_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ref_dec(input logic [6:0] fn7, input logic [2:0] fn3);
        logic [3:0] base[8];
        base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        if (fn7 == 7'h00) return {1'b0, base[fn3]};
        if (fn7 == 7'h20 && fn3 == 3'd0) return {1'b0, 4'd1};
        if (fn7 == 7'h20 && fn3 == 3'd5) return {1'b0, 4'd7};
        if (fn7 == 7'h01) return 5'd0;
        return {1'b1, 4'd0};
    endfunction

    function automatic logic [31:0] ref_m(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int unsigned exp_lat(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
`ifdef ALU_MULDIV_EARLY_OUT_EN
        logic [31:0] m;
        int hb;
        if (op[2]) begin
            if (b == 0 || ((op == 3'd4 || op == 3'd6) && a == MinInt && b == 32'hFFFF_FFFF))
                return 1;
            return XLEN + 1;
        end
        m  = (op == 3'd1 && b[31]) ? 32'd0 - b : b;
        hb = 0;
        for (int i = 0; i < 32; i++) if (m[i]) hb = i;
        return hb + 2;
`else
        return XLEN + 1 + 0 * (op + a + b);
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return MinInt;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 20));
            5:       return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Present one M request when idle; the expected result is queued for the monitor.
    task automatic do_mreq(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        int guard = 0;
        @(negedge clk);
        while (!ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("ready_timeout", 64'(guard < 100), 64'd1);
        is_op = 1'b1; f7 = 7'h01; f3 = op; rs1 = a; rs2 = b; valid = 1'b1;
        #1;
        check("stall_on_request", 64'(stall), 64'd1);
        exp_q.push_back(exp);
        lat_q.push_back(exp_lat(op, a, b));
        t0_q.push_back(cyc);
        @(negedge clk);
        check("busy_not_ready", 64'(ready), 64'd0);
        valid = 1'b0; f3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    endtask

    always @(negedge clk) begin
        if (res_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result_valid", 64'd1, 64'd0);
            end else begin
                logic [31:0] e;
                int unsigned l, t;
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                t = t0_q.pop_front();
                check("m_result", 64'(result), 64'(e));
                check("m_latency", 64'(cyc - t), 64'(l));
            end
        end
    end

    initial begin
        logic [6:0] f7_list[6];
        logic [2:0] rop;
        logic [31:0] ra, rb;
        rst_n = 1'b0; valid = 1'b0; is_op = 1'b0; f3 = '0; f7 = '0; rs1 = '0; rs2 = '0;
        repeat (3) @(negedge clk);
        check("reset_result", 64'(result), 64'd0);
        check("reset_result_valid", 64'(res_valid), 64'd0);
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_stall", 64'(stall), 64'd0);
        rst_n = 1'b1;

        f7_list = '{7'h00, 7'h20, 7'h01, 7'h40, 7'h02, 7'($urandom_range(3, 31))};
        is_op = 1'b1;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 8; j++) begin
                f7 = f7_list[i]; f3 = 3'(j);
                #1;
                check($sformatf("decode_f7_%0h_f3_%0d", f7, f3), 64'({illegal, alu_op}),
                      64'(ref_dec(f7, f3)));
            end
        end
        is_op = 1'b0; f7 = 7'h55; f3 = 3'd3;
        #1;
        check("not_op_illegal", 64'(illegal), 64'd0);

        do_mreq(3'd1, MinInt, MinInt, 32'h4000_0000);
        do_mreq(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        do_mreq(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        do_mreq(3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF);
        do_mreq(3'd7, 32'h1234, 32'd0, 32'h1234);
        do_mreq(3'd4, MinInt, 32'hFFFF_FFFF, MinInt);
        do_mreq(3'd6, MinInt, 32'hFFFF_FFFF, 32'd0);

        // Abort a DIVU with a one-edge reset; no result may appear afterwards.
        @(negedge clk);
        while (!ready) @(negedge clk);
        is_op = 1'b1; f7 = 7'h01; f3 = 3'd5; rs1 = 32'hFFFF; rs2 = 32'd3; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_no_valid", 64'(res_valid), 64'd0);
        repeat (40) @(negedge clk);
        do_mreq(3'd0, 32'd3, 32'd5, 32'd15);

        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick();
            rb  = pick();
            do_mreq(rop, ra, rb, ref_m(rop, ra, rb));
        end

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
